// File: rtl/fft_stage_r2_gen.sv
// Radix-2 DIF FFT stage: butterfly at lane distance PAIR, W8-class twiddle, optional 1/2 scaling.
// Three-register valid/stall pipeline (P1 capture, P2 butterfly, P3 twiddle + saturate).
module fft_stage_r2_gen #(
    parameter int DATA  = 12,
    parameter int ARRAY = 16,
    parameter int PAIR  = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        valid_in,
    output logic                        ready_in,
    input  logic                        scale_in,
    input  logic [ARRAY-1:0][DATA-1:0]  din_re,
    input  logic [ARRAY-1:0][DATA-1:0]  din_im,
    output logic                        valid_out,
    input  logic                        ready_out,
    output logic [ARRAY-1:0][DATA:0]    dout_re,
    output logic [ARRAY-1:0][DATA:0]    dout_im,
    output logic                        ovf_sticky,
    input  logic                        clr
);

    localparam int BW = DATA + 1;
    localparam int TW = DATA + 2;
    localparam int MW = TW + 9;
    localparam logic signed [MW-1:0] C181 = MW'(181);
    localparam logic signed [MW-1:0] C128 = MW'(128);

    // Handshake: a beat moves on an edge only when en=1; the whole pipe freezes
    // while the output holds a valid beat the sink refuses. ready_in mirrors en.
    logic en;
    assign en       = !(valid_out && !ready_out);
    assign ready_in = en;

    logic                       p1_valid, p1_scale;
    logic [ARRAY-1:0][DATA-1:0] p1_re, p1_im;
    logic                       p2_valid;
    logic [ARRAY-1:0][BW-1:0]   p2_re, p2_im;
    logic [ARRAY-1:0][BW-1:0]   bf_re, bf_im;
    logic [ARRAY-1:0][BW-1:0]   sat_re, sat_im;
    logic [2*ARRAY-1:0]         clip;

    function automatic logic [BW-1:0] halve(input logic [BW-1:0] x, input logic sc);
        logic [BW:0] t;
        t = {x[BW-1], x} + {{BW{1'b0}}, 1'b1};
        return sc ? t[BW:1] : x;
    endfunction

    // C(t) = (t*181 + 128) >>> 8, i.e. multiply by 1/sqrt(2) with round-half-up.
    function automatic logic [TW-1:0] cmul(input logic [TW-1:0] t);
        logic signed [MW-1:0] m;
        m = $signed({{(MW-TW){t[TW-1]}}, t}) * C181 + C128;
        return m[TW+7:8];
    endfunction

    for (genvar g = 0; g < ARRAY / (2 * PAIR); g++) begin : g_grp
        for (genvar p = 0; p < PAIR; p++) begin : g_bf
            localparam int I = g * 2 * PAIR + p;
            localparam int J = I + PAIR;
            logic [BW-1:0] ar, ai, br, bi;
            assign ar = {p1_re[I][DATA-1], p1_re[I]};
            assign ai = {p1_im[I][DATA-1], p1_im[I]};
            assign br = {p1_re[J][DATA-1], p1_re[J]};
            assign bi = {p1_im[J][DATA-1], p1_im[J]};
            assign bf_re[I] = halve(ar + br, p1_scale);
            assign bf_im[I] = halve(ai + bi, p1_scale);
            assign bf_re[J] = halve(ar - br, p1_scale);
            assign bf_im[J] = halve(ai - bi, p1_scale);
        end
    end

    // Lower-half lanes of each group carry the difference term and get W8^k.
    for (genvar l = 0; l < ARRAY; l++) begin : g_tw
        localparam int K = ((l / PAIR) % 2 == 1) ? (l % PAIR) * (4 / PAIR) : 0;
        logic [TW-1:0] a, b, tr, ti;
        assign a = {p2_re[l][BW-1], p2_re[l]};
        assign b = {p2_im[l][BW-1], p2_im[l]};
        if (K == 0) begin : g_k0
            assign tr = a;
            assign ti = b;
        end else if (K == 1) begin : g_k1
            assign tr = cmul(a + b);
            assign ti = cmul(b - a);
        end else if (K == 2) begin : g_k2
            assign tr = b;
            assign ti = -a;
        end else begin : g_k3
            assign tr = cmul(b - a);
            assign ti = cmul(-a - b);
        end
        assign clip[2*l]   = tr[TW-1] ^ tr[BW-1];
        assign clip[2*l+1] = ti[TW-1] ^ ti[BW-1];
        assign sat_re[l] = clip[2*l]   ? {tr[TW-1], {(BW-1){~tr[TW-1]}}} : tr[BW-1:0];
        assign sat_im[l] = clip[2*l+1] ? {ti[TW-1], {(BW-1){~ti[TW-1]}}} : ti[BW-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p1_valid <= 1'b0;
            p1_scale <= 1'b0;
            p1_re    <= '0;
            p1_im    <= '0;
            p2_valid <= 1'b0;
            p2_re    <= '0;
            p2_im    <= '0;
        end else if (en) begin
            p1_valid <= valid_in;
            p1_scale <= scale_in;
            p1_re    <= din_re;
            p1_im    <= din_im;
            p2_valid <= p1_valid;
            p2_re    <= bf_re;
            p2_im    <= bf_im;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_out  <= 1'b0;
            dout_re    <= '0;
            dout_im    <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            if (clr)
                ovf_sticky <= 1'b0;
            else if (en && p2_valid && |clip)
                ovf_sticky <= 1'b1;
            if (en) begin
                valid_out <= p2_valid;
                dout_re   <= sat_re;
                dout_im   <= sat_im;
            end
        end
    end

endmodule

// File: tb/tb_fft_stage_r2_gen.sv
// Bench for fft_stage_r2_gen: directed test-plan beats plus randomized streams under backpressure,
// scored against an integer complex-arithmetic model of the stage.
module tb_fft_stage_r2_gen;

    localparam int DATA  = 12;
    localparam int ARRAY = 16;
    localparam int PAIR  = 4;
    localparam int CW    = ARRAY * (DATA + 1);

    logic                       clk = 1'b0;
    logic                       rstn = 1'b0;
    logic                       valid_in = 1'b0;
    logic                       ready_in;
    logic                       scale_in = 1'b0;
    logic [ARRAY-1:0][DATA-1:0] din_re = '0;
    logic [ARRAY-1:0][DATA-1:0] din_im = '0;
    logic                       valid_out;
    logic                       ready_out = 1'b1;
    logic [ARRAY-1:0][DATA:0]   dout_re, dout_im;
    logic                       ovf_sticky;
    logic                       clr = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int n_out = 0;
    logic [CW-1:0] exp_re_q[$];
    logic [CW-1:0] exp_im_q[$];
    logic          prev_stall = 1'b0;
    logic [CW-1:0] prev_re, prev_im;
    bit            drv_done;

    always #5 clk = ~clk;

    fft_stage_r2_gen #(.DATA(DATA), .ARRAY(ARRAY), .PAIR(PAIR)) dut (
        .clk(clk), .rstn(rstn),
        .valid_in(valid_in), .ready_in(ready_in), .scale_in(scale_in),
        .din_re(din_re), .din_im(din_im),
        .valid_out(valid_out), .ready_out(ready_out),
        .dout_re(dout_re), .dout_im(dout_im),
        .ovf_sticky(ovf_sticky), .clr(clr)
    );

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int floor_div(input int n, input int d);
        int q;
        q = n / d;
        if ((n % d != 0) && ((n < 0) != (d < 0))) q--;
        return q;
    endfunction

    function automatic int c_mul(input int t);
        return floor_div(t * 181 + 128, 256);
    endfunction

    function automatic int sat(input int t);
        int hi, lo;
        hi = (1 << DATA) - 1;
        lo = -(1 << DATA);
        return (t > hi) ? hi : ((t < lo) ? lo : t);
    endfunction

    // Reference: complex butterfly, then rotate the difference by exp(-j*pi*k/4)
    // as (1-j) for the odd eighth followed by k/2 quarter turns, then 1/sqrt(2).
    task automatic ref_model(input logic [ARRAY-1:0][DATA-1:0] ir, input logic [ARRAY-1:0][DATA-1:0] ii,
                             input bit sc, output logic [ARRAY-1:0][DATA:0] orr,
                             output logic [ARRAY-1:0][DATA:0] oi);
        int ar, ai, br, bi, ur, ui, vr, vi, tmp, k;
        orr = '0;
        oi  = '0;
        for (int i = 0; i < ARRAY; i++) begin
            if ((i / PAIR) % 2 == 0) begin
                ar = int'($signed(ir[i]));
                ai = int'($signed(ii[i]));
                br = int'($signed(ir[i+PAIR]));
                bi = int'($signed(ii[i+PAIR]));
                ur = ar + br; ui = ai + bi;
                vr = ar - br; vi = ai - bi;
                if (sc) begin
                    ur = floor_div(ur + 1, 2); ui = floor_div(ui + 1, 2);
                    vr = floor_div(vr + 1, 2); vi = floor_div(vi + 1, 2);
                end
                k = (i % PAIR) * (4 / PAIR);
                if (k % 2 == 1) begin
                    tmp = vr + vi;
                    vi  = vi - vr;
                    vr  = tmp;
                end
                for (int q = 0; q < k / 2; q++) begin
                    tmp = vr;
                    vr  = vi;
                    vi  = -tmp;
                end
                if (k % 2 == 1) begin
                    vr = c_mul(vr);
                    vi = c_mul(vi);
                end
                orr[i]      = (DATA+1)'(sat(ur));
                oi[i]       = (DATA+1)'(sat(ui));
                orr[i+PAIR] = (DATA+1)'(sat(vr));
                oi[i+PAIR]  = (DATA+1)'(sat(vi));
            end
        end
    endtask

    // Scoreboard: outputs checked before this cycle's accepted input is modelled.
    always @(negedge clk) begin
        logic [ARRAY-1:0][DATA:0] er, ei;
        if (!rstn) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_re", dout_re, prev_re);
                check("stall_hold_im", dout_im, prev_im);
                check("stall_hold_valid", CW'(valid_out), CW'(1'b1));
            end
            if (valid_out && !ready_out)
                check("stall_ready_in", CW'(ready_in), CW'(1'b0));
            if (valid_out && ready_out) begin
                n_out++;
                if (exp_re_q.size() == 0) begin
                    check("unexpected_beat", CW'(valid_out), CW'(1'b0));
                end else begin
                    check("beat_re", dout_re, exp_re_q.pop_front());
                    check("beat_im", dout_im, exp_im_q.pop_front());
                end
            end
            if (valid_in && ready_in) begin
                ref_model(din_re, din_im, scale_in, er, ei);
                exp_re_q.push_back(er);
                exp_im_q.push_back(ei);
            end
            prev_stall <= valid_out && !ready_out;
            prev_re    <= dout_re;
            prev_im    <= dout_im;
        end
    end

    task automatic clear_din();
        din_re   = '0;
        din_im   = '0;
        scale_in = 1'b0;
    endtask

    task automatic set_lane(input int l, input int re, input int im);
        din_re[l] = DATA'(re);
        din_im[l] = DATA'(im);
    endtask

    task automatic check_lane(input string tag, input int l, input int re, input int im);
        logic [DATA:0] r, i;
        r = (DATA+1)'(re);
        i = (DATA+1)'(im);
        check({tag, "_re"}, CW'(dout_re[l]), CW'(r));
        check({tag, "_im"}, CW'(dout_im[l]), CW'(i));
    endtask

    // Present the staged beat (called at posedge+1, pipe empty) and stop at the
    // negedge where it appears on the output.
    task automatic present_and_wait(input string tag);
        int c;
        valid_in = 1'b1;
        @(negedge clk);
        check({tag, "_ready_in"}, CW'(ready_in), CW'(1'b1));
        @(posedge clk); #1;
        valid_in = 1'b0;
        for (c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (valid_out) break;
        end
        check({tag, "_latency"}, CW'(c), CW'(3));
    endtask

    task automatic rand_din();
        for (int l = 0; l < ARRAY; l++) begin
            din_re[l] = DATA'($urandom);
            din_im[l] = DATA'($urandom);
            if ($urandom_range(0, 7) == 0) din_re[l] = $urandom_range(0, 1) ? 12'h7ff : 12'h800;
            if ($urandom_range(0, 7) == 0) din_im[l] = $urandom_range(0, 1) ? 12'h7ff : 12'h800;
        end
        scale_in = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_beats(input int n);
        bit acc;
        int guard;
        for (int b = 0; b < n; b++) begin
            rand_din();
            valid_in = 1'b1;
            guard = 0;
            do begin
                @(negedge clk);
                acc = ready_in;
                @(posedge clk); #1;
                guard++;
            end while (!acc && guard < 200);
            if (!acc) check("drive_timeout", CW'(acc), CW'(1'b1));
        end
        valid_in = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (exp_re_q.size() != 0 && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("drain_empty", CW'(exp_re_q.size()), CW'(0));
    endtask

    initial begin
        #(300000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        #2;
        check("rst_valid_out", CW'(valid_out), CW'(1'b0));
        check("rst_dout_re", dout_re, '0);
        check("rst_dout_im", dout_im, '0);
        check("rst_ovf", CW'(ovf_sticky), CW'(1'b0));
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_ready_in", CW'(ready_in), CW'(1'b1));
        ready_out = 1'b0;
        #1;
        check("empty_no_stall", CW'(ready_in), CW'(1'b1));
        ready_out = 1'b1;

        // All lanes (100, 0)
        @(posedge clk); #1;
        clear_din();
        for (int l = 0; l < ARRAY; l++) set_lane(l, 100, 0);
        present_and_wait("dc");
        for (int l = 0; l < ARRAY; l++) check_lane("dc_lane", l, ((l / PAIR) % 2 == 0) ? 200 : 0, 0);

        @(posedge clk); #1;
        clear_din(); set_lane(1, 100, 0);
        present_and_wait("k1");
        check_lane("k1_lane1", 1, 100, 0);
        check_lane("k1_lane5", 5, 71, -71);
        check_lane("k1_lane0", 0, 0, 0);

        @(posedge clk); #1;
        clear_din(); set_lane(2, 0, 50);
        present_and_wait("k2");
        check_lane("k2_lane6", 6, 50, 0);
        check_lane("k2_lane2", 2, 0, 50);

        @(posedge clk); #1;
        clear_din(); set_lane(3, 100, 0);
        present_and_wait("k3");
        check_lane("k3_lane7", 7, -71, -71);
        check("no_ovf_yet", CW'(ovf_sticky), CW'(1'b0));

        // Saturation on a k=1 lane
        @(posedge clk); #1;
        clear_din(); set_lane(1, 2047, 2047); set_lane(5, -2048, -2048);
        present_and_wait("sat");
        check_lane("sat_lane5", 5, 4095, 0);
        check_lane("sat_lane1", 1, -1, -1);
        check("sat_ovf_set", CW'(ovf_sticky), CW'(1'b1));

        @(posedge clk); #1;
        clear_din(); set_lane(0, 5, 5);
        present_and_wait("hold");
        check("ovf_held", CW'(ovf_sticky), CW'(1'b1));

        // clr coinciding with the P3 load of a saturating beat
        @(posedge clk); #1;
        clear_din(); set_lane(1, 2047, 2047); set_lane(5, -2048, -2048);
        valid_in = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        valid_in = 1'b0;
        @(negedge clk);
        check("ovf_before_clr", CW'(ovf_sticky), CW'(1'b1));
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        check("clr_priority_valid", CW'(valid_out), CW'(1'b1));
        check_lane("clr_sat_lane5", 5, 4095, 0);
        check("clr_priority_ovf", CW'(ovf_sticky), CW'(1'b0));

        // Scaling
        @(posedge clk); #1;
        clear_din(); set_lane(0, 3, -3); scale_in = 1'b1;
        present_and_wait("scale");
        check_lane("scale_lane0", 0, 2, -1);
        check_lane("scale_lane4", 4, 2, -1);
        scale_in = 1'b0;

        // Backpressure window over a 10-beat stream
        drain();
        @(posedge clk); #1;
        n0 = n_out;
        fork
            drive_beats(10);
            begin
                repeat (5) @(posedge clk);
                #1 ready_out = 1'b0;
                repeat (5) @(posedge clk);
                #1 ready_out = 1'b1;
            end
        join
        drain();
        check("bp_count", CW'(n_out - n0), CW'(10));

        // Random stream with random sink backpressure
        @(posedge clk); #1;
        n0 = n_out;
        drv_done = 1'b0;
        fork
            begin
                drive_beats(80);
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk); #1;
                    ready_out = ($urandom_range(0, 3) != 0);
                end
                ready_out = 1'b1;
            end
        join
        drain();
        check("rand_count", CW'(n_out - n0), CW'(80));

        // Reset in the middle of a stream
        @(posedge clk); #1;
        for (int b = 0; b < 6; b++) begin
            rand_din();
            valid_in = 1'b1;
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("midrst_valid_out", CW'(valid_out), CW'(1'b0));
        check("midrst_dout_re", dout_re, '0);
        check("midrst_dout_im", dout_im, '0);
        exp_re_q.delete();
        exp_im_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("midrst_ready_in", CW'(ready_in), CW'(1'b1));
        @(posedge clk); #1;
        clear_din(); set_lane(1, 100, 0);
        present_and_wait("after_rst");
        check_lane("after_rst_lane5", 5, 71, -71);
        repeat (6) @(negedge clk);
        check("after_rst_single", CW'(exp_re_q.size()), CW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
